mem_multi_seq: RTL and testbench



---
 rtl/mem_multi_seq_if.sv | 38 +++
 rtl/mem_multi_seq.sv | 123 ++++++++++++
 tb/tb_mem_multi_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_multi_seq_if.sv
// Bus bundle between the MEM-stage multi-register sequencer and the
// pipeline / register file / data memory around it.
interface mem_multi_seq_if #(
  parameter int DW = 16
);
  logic          valid_mem;
  logic [3:0]    instr_mem_4;
  logic [DW-1:0] base_mem_16;
  logic [7:0]    imm_mem_8;
  logic          flush_mem;
  logic [DW-1:0] dmem_rdata_16;
  logic [DW-1:0] rf_rdata_16;
  logic [2:0]    k_mem_3;
  logic [2:0]    reg_addr_3;
  logic [DW-1:0] mem_addr_16;
  logic          rf_we;
  logic [DW-1:0] rf_wdata_16;
  logic          dmem_we;
  logic [DW-1:0] dmem_wdata_16;
  logic          busy;
  logic          done;

  // Sequencer side
  modport master (
    input  valid_mem, instr_mem_4, base_mem_16, imm_mem_8, flush_mem,
           dmem_rdata_16, rf_rdata_16,
    output k_mem_3, reg_addr_3, mem_addr_16, rf_we, rf_wdata_16,
           dmem_we, dmem_wdata_16, busy, done
  );

  // Pipeline / memory side
  modport slave (
    output valid_mem, instr_mem_4, base_mem_16, imm_mem_8, flush_mem,
           dmem_rdata_16, rf_rdata_16,
    input  k_mem_3, reg_addr_3, mem_addr_16, rf_we, rf_wdata_16,
           dmem_we, dmem_wdata_16, busy, done
  );
endinterface

// File: rtl/mem_multi_seq.sv
// MEM-stage transfer sequencer for LM/SM/LA/SA. Each multi-register opcode
// runs eight one-per-cycle transfers; slot 0 is served combinationally in the
// cycle the opcode arrives, slots 1..7 from latched opcode/mask/pointer.
module mem_multi_seq #(
  parameter int DW = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_multi_seq_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic          store_q, store_d;
  logic [7:0]    mask_q, mask_d;
  logic [DW-1:0] addr_ptr_q, addr_ptr_d;

  logic          start_s;
  logic          en_s;
  logic [2:0]    k_out_s;
  logic [DW-1:0] mem_addr_s;
  logic          rf_we_s;
  logic          dmem_we_s;
  logic          busy_s;
  logic          done_s;

  // Next-state and per-cycle transfer outputs. Start is qualified with reset_n
  // so the live-input slot-0 path stays quiet while reset is held.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    store_d    = store_q;
    mask_d     = mask_q;
    addr_ptr_d = addr_ptr_q;
    en_s       = 1'b0;
    k_out_s    = 3'd0;
    mem_addr_s = {DW{1'b0}};
    rf_we_s    = 1'b0;
    dmem_we_s  = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    start_s    = reset_n & bus.valid_mem & ~bus.flush_mem &
                 (bus.instr_mem_4[3:2] == 2'b11);
    case (state_q)
      IDLE: begin
        k_d = 3'd0;
        if (start_s) begin
          // LA/SA (bit 1 set) transfer every register; LM/SM follow the mask
          en_s       = bus.instr_mem_4[1] ? 1'b1 : bus.imm_mem_8[0];
          mem_addr_s = bus.base_mem_16;
          rf_we_s    = en_s & ~bus.instr_mem_4[0];
          dmem_we_s  = en_s & bus.instr_mem_4[0];
          store_d    = bus.instr_mem_4[0];
          mask_d     = bus.instr_mem_4[1] ? 8'hFF : bus.imm_mem_8;
          addr_ptr_d = bus.base_mem_16 + {{(DW-1){1'b0}}, en_s};
          k_d        = 3'd1;
          state_d    = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        busy_s     = 1'b1;
        k_out_s    = k_q;
        mem_addr_s = addr_ptr_q;
        en_s       = mask_q[k_q];
        if (bus.flush_mem) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end else begin
          rf_we_s    = en_s & ~store_q;
          dmem_we_s  = en_s & store_q;
          // disabled slots hold the pointer so enabled registers pack densely
          addr_ptr_d = addr_ptr_q + {{(DW-1){1'b0}}, en_s};
          if (k_q == 3'd7) begin
            done_s  = 1'b1;
            state_d = IDLE;
            k_d     = 3'd0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      k_q        <= 3'd0;
      store_q    <= 1'b0;
      mask_q     <= 8'h00;
      addr_ptr_q <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      store_q    <= store_d;
      mask_q     <= mask_d;
      addr_ptr_q <= addr_ptr_d;
    end
  end

  assign bus.k_mem_3       = k_out_s;
  assign bus.reg_addr_3    = k_out_s;
  assign bus.mem_addr_16   = mem_addr_s;
  assign bus.rf_we         = rf_we_s;
  assign bus.dmem_we       = dmem_we_s;
  assign bus.busy          = busy_s;
  assign bus.done          = done_s;
  assign bus.rf_wdata_16   = bus.dmem_rdata_16;
  assign bus.dmem_wdata_16 = bus.rf_rdata_16;

endmodule

// File: tb/tb_mem_multi_seq.sv
// Scoreboard bench for mem_multi_seq: stimulus pushes the expected transfer
// for each enabled or done cycle, a monitor pops and compares on the falling
// edge whenever the DUT asserts rf_we, dmem_we or done.
module tb_mem_multi_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_multi_seq_if #(.DW(16)) bus ();

  mem_multi_seq #(.DW(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        rfwe;
    logic        dmwe;
    logic        dn;
    logic [2:0]  k;
    logic [15:0] addr;
    logic [15:0] rfwd;
    logic [15:0] dmwd;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each presented transfer against the scoreboard head
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rf_we || bus.dmem_we || bus.done) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_xfer: got k=%0d addr=%h rf_we=%b dmem_we=%b done=%b expected no transfer (t=%0t)",
                   bus.k_mem_3, bus.mem_addr_16, bus.rf_we, bus.dmem_we, bus.done, $time);
        end else begin
          e = q.pop_front();
          chk("rf_we",    {31'd0, bus.rf_we},   {31'd0, e.rfwe});
          chk("dmem_we",  {31'd0, bus.dmem_we}, {31'd0, e.dmwe});
          chk("done",     {31'd0, bus.done},    {31'd0, e.dn});
          chk("k_mem",    {29'd0, bus.k_mem_3}, {29'd0, e.k});
          chk("reg_addr", {29'd0, bus.reg_addr_3}, {29'd0, e.k});
          chk("mem_addr", {16'd0, bus.mem_addr_16}, {16'd0, e.addr});
          if (e.rfwe) chk("rf_wdata", {16'd0, bus.rf_wdata_16}, {16'd0, e.rfwd});
          if (e.dmwe) chk("dmem_wdata", {16'd0, bus.dmem_wdata_16}, {16'd0, e.dmwd});
        end
      end
    end
  end

  // Watchdog against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.valid_mem   = 1'b0;
    bus.instr_mem_4 = 4'b0000;
    bus.base_mem_16 = 16'h0000;
    bus.imm_mem_8   = 8'h00;
    bus.flush_mem   = 1'b0;
  endtask

  // One multi-register instruction; entered and left at posedge+1.
  // flush_k/reset_k select the slot at which the event is injected (8 = none).
  task automatic run_seq(input logic [3:0] op, input logic [15:0] base,
                         input logic [7:0] mask, input logic [7:0][15:0] exp_addr,
                         input int flush_k, input int reset_k);
    logic [7:0]  m;
    logic [15:0] rd_rf;
    logic [15:0] rd_dm;
    exp_t        e;
    m = op[1] ? 8'hFF : mask;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        bus.valid_mem   = 1'b1;
        bus.instr_mem_4 = op;
        bus.base_mem_16 = base;
        bus.imm_mem_8   = mask;
      end else begin
        // garbage while busy; a multi opcode sits on the k=7 cycle
        bus.instr_mem_4 = (k == 7) ? 4'b1110 : ((k % 2 == 1) ? 4'b0100 : 4'b1101);
        bus.base_mem_16 = 16'hDEAD;
        bus.imm_mem_8   = ~mask;
      end
      rd_rf = 16'h1000 + 16'(k) * 16'h0011;
      rd_dm = 16'h2000 + 16'(k) * 16'h0101;
      bus.rf_rdata_16   = rd_rf;
      bus.dmem_rdata_16 = rd_dm;
      if (k == reset_k) begin
        reset_n = 1'b0;
        #1;
        chk("rst_busy",    {31'd0, bus.busy},    32'd0);
        chk("rst_done",    {31'd0, bus.done},    32'd0);
        chk("rst_rf_we",   {31'd0, bus.rf_we},   32'd0);
        chk("rst_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
        chk("rst_k",       {29'd0, bus.k_mem_3}, 32'd0);
        chk("rst_addr",    {16'd0, bus.mem_addr_16}, 32'd0);
        drive_idle();
        @(posedge clk); #1;
        reset_n = 1'b1;
        break;
      end
      if (k == 1) chk("busy_mid", {31'd0, bus.busy}, 32'd1);
      if (k == flush_k) begin
        bus.flush_mem = 1'b1;
      end else if (m[k] || k == 7) begin
        e.rfwe = m[k] & ~op[0];
        e.dmwe = m[k] & op[0];
        e.dn   = (k == 7);
        e.k    = 3'(k);
        e.addr = exp_addr[k];
        e.rfwd = rd_dm;
        e.dmwd = rd_rf;
        q.push_back(e);
      end
      @(posedge clk); #1;
      if (k == flush_k) break;
    end
    drive_idle();
    @(negedge clk);
    chk("end_busy", {31'd0, bus.busy},    32'd0);
    chk("end_k",    {29'd0, bus.k_mem_3}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle();
    bus.rf_rdata_16   = 16'h0000;
    bus.dmem_rdata_16 = 16'h0000;
    #1;
    chk("reset_busy",    {31'd0, bus.busy},    32'd0);
    chk("reset_done",    {31'd0, bus.done},    32'd0);
    chk("reset_rf_we",   {31'd0, bus.rf_we},   32'd0);
    chk("reset_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("reset_k",       {29'd0, bus.k_mem_3}, 32'd0);
    chk("reset_addr",    {16'd0, bus.mem_addr_16}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // non-multi opcode while idle: no start
    bus.valid_mem   = 1'b1;
    bus.instr_mem_4 = 4'b0100;
    bus.base_mem_16 = 16'h1234;
    bus.imm_mem_8   = 8'hFF;
    #1;
    chk("nomulti_rf_we",   {31'd0, bus.rf_we},   32'd0);
    chk("nomulti_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("nomulti_addr",    {16'd0, bus.mem_addr_16}, 32'd0);
    @(posedge clk); #1;
    chk("nomulti_busy", {31'd0, bus.busy},    32'd0);
    chk("nomulti_k",    {29'd0, bus.k_mem_3}, 32'd0);
    drive_idle();
    @(posedge clk); #1;

    // LA base 0x0040
    run_seq(4'b1110, 16'h0040, 8'h00,
            {16'h0047, 16'h0046, 16'h0045, 16'h0044, 16'h0043, 16'h0042, 16'h0041, 16'h0040}, 8, 8);
    // SM mask 1010_0101 base 0x0100
    run_seq(4'b1101, 16'h0100, 8'b1010_0101,
            {16'h0103, 16'h0103, 16'h0102, 16'h0102, 16'h0102, 16'h0101, 16'h0101, 16'h0100}, 8, 8);
    // LM mask 0: only the done slot, pointer held at base
    run_seq(4'b1100, 16'h0200, 8'h00,
            {16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200}, 8, 8);
    // SA base 0xFFFE wraps
    run_seq(4'b1111, 16'hFFFE, 8'h00,
            {16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}, 8, 8);
    // LA flushed at k=3
    run_seq(4'b1110, 16'h0300, 8'h00,
            {16'h0307, 16'h0306, 16'h0305, 16'h0304, 16'h0303, 16'h0302, 16'h0301, 16'h0300}, 3, 8);
    // SM mask FF, reset at k=4
    run_seq(4'b1101, 16'h0400, 8'hFF,
            {16'h0407, 16'h0406, 16'h0405, 16'h0404, 16'h0403, 16'h0402, 16'h0401, 16'h0400}, 8, 4);
    // LA again after reset to confirm clean restart
    run_seq(4'b1110, 16'h0500, 8'h00,
            {16'h0507, 16'h0506, 16'h0505, 16'h0504, 16'h0503, 16'h0502, 16'h0501, 16'h0500}, 8, 8);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
